// File: rtl/keygen_norm_check_if.sv
// keygen_norm_check_if: handshake and result bundle between the keygen controller, poly_small_sqnorm and the norm checker
interface keygen_norm_check_if #(
    parameter int s_bit = 21
);
    logic             start;
    logic             s_valid;
    logic [s_bit-1:0] s;
    logic             busy;
    logic             done;
    logic             pass;
    logic [s_bit:0]   sum;
    logic             err;

    modport master (output start, s_valid, s, input busy, done, pass, sum, err);
    modport slave  (input start, s_valid, s, output busy, done, pass, sum, err);
endinterface

// File: rtl/keygen_norm_check.sv
// keygen_norm_check: sums ||f||^2 and ||g||^2 and returns a registered pass/fail verdict against the keygen bound
module keygen_norm_check #(
    parameter int logn  = 9,
    parameter int s_bit = (logn == 9) ? 21 : 20,
    parameter int BOUND = 16822
) (
    input logic                clk,
    input logic                rst,
    keygen_norm_check_if.slave bus
);
    localparam int SW = s_bit + 1;

    typedef enum logic [2:0] {IDLE, WAIT_F, WAIT_G, CMP, DONE} state_t;

    state_t           state_q, state_d;
    logic             s_valid_q;
    logic [s_bit-1:0] norm_f_q, norm_f_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic             pass_q, pass_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;
    logic             s_edge;
    logic             viol;

    // A held s_valid level counts as a single result
    assign s_edge = bus.s_valid & ~s_valid_q;

    assign bus.busy = (state_q == WAIT_F) | (state_q == WAIT_G) | (state_q == CMP);
    assign bus.done = (state_q == DONE);
    assign bus.pass = pass_q;
    assign bus.sum  = sum_q;
    assign bus.err  = err_q;

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s_valid_q <= 1'b0;
            norm_f_q  <= '0;
            sum_q     <= '0;
            pass_q    <= 1'b0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_valid_q <= bus.s_valid;
            norm_f_q  <= norm_f_d;
            sum_q     <= sum_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
        end
    end

    // Next state, datapath updates and protocol-violation reporting
    always_comb begin
        state_d  = state_q;
        norm_f_d = norm_f_q;
        sum_d    = sum_q;
        pass_d   = pass_q;
        viol     = 1'b0;
        if (bus.start) begin
            state_d  = WAIT_F;
            norm_f_d = '0;
            sum_d    = '0;
            pass_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: viol = s_edge;
                WAIT_F: if (s_edge) begin
                    state_d  = WAIT_G;
                    norm_f_d = bus.s;
                end
                WAIT_G: if (s_edge) begin
                    state_d = CMP;
                    sum_d   = {1'b0, norm_f_q} + {1'b0, bus.s};
                end
                CMP: begin
                    state_d = DONE;
                    pass_d  = (sum_q <= SW'(BOUND));
                    viol    = s_edge;
                end
                DONE: begin
                    state_d = IDLE;
                    viol    = s_edge;
                end
                default: state_d = IDLE;
            endcase
        end
        // An error that would land on the done cycle is held back one cycle so the two never coincide
        err_d  = (viol | pend_q) & (state_d != DONE);
        pend_d = (viol | pend_q) & (state_d == DONE);
    end
endmodule

// File: tb/tb_keygen_norm_check.sv
// tb_keygen_norm_check: directed checks of the keygen norm-bound checker
module tb_keygen_norm_check;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    keygen_norm_check_if #(.s_bit(21)) bus ();

    keygen_norm_check #(.logn(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [20:0] v);
        bus.s = v;
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic run(input logic [20:0] f, input logic [20:0] g);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        pulse(f);
        tick();
        pulse(g);
        chk("done_low_k1", bus.done, 0);
        chk("busy_k1", bus.busy, 1);
        tick();
        chk("done_k2", bus.done, 1);
        chk("busy_low_k2", bus.busy, 0);
        chk("err_low_k2", bus.err, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s = '0;
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", bus.busy, 0);

        run(21'd5000, 21'd6000);
        chk("basic_sum", bus.sum, 11000);
        chk("basic_pass", bus.pass, 1);
        tick();
        chk("basic_done_one_cycle", bus.done, 0);
        chk("basic_pass_held", bus.pass, 1);
        chk("basic_sum_held", bus.sum, 11000);

        run(21'd10000, 21'd6822);
        chk("bound_eq_sum", bus.sum, 16822);
        chk("bound_eq_pass", bus.pass, 1);
        tick();
        run(21'd10000, 21'd6823);
        chk("bound_over_sum", bus.sum, 16823);
        chk("bound_over_pass", bus.pass, 0);
        tick();

        run(21'h1FFFFF, 21'h1FFFFF);
        chk("wide_sum", bus.sum, 4194302);
        chk("wide_pass", bus.pass, 0);
        tick();

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.s = 21'd100;
        bus.s_valid = 1'b1;
        repeat (5) tick();
        bus.s_valid = 1'b0;
        chk("held_no_g", bus.busy, 1);
        tick();
        pulse(21'd200);
        tick();
        chk("held_done", bus.done, 1);
        chk("held_sum", bus.sum, 300);
        chk("held_pass", bus.pass, 1);
        tick();
        pulse(21'd999);
        chk("stray_err", bus.err, 1);
        chk("stray_busy", bus.busy, 0);
        tick();
        chk("stray_err_once", bus.err, 0);
        chk("stray_sum", bus.sum, 300);
        chk("stray_pass", bus.pass, 1);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        pulse(21'd9000);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart_sum_clr", bus.sum, 0);
        chk("restart_busy", bus.busy, 1);
        pulse(21'd1);
        tick();
        pulse(21'd2);
        chk("restart_sum", bus.sum, 3);
        tick();
        chk("restart_done", bus.done, 1);
        chk("restart_pass", bus.pass, 1);
        tick();

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        pulse(21'd7);
        tick();
        pulse(21'd8);
        chk("cmp_sum", bus.sum, 15);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_pass", bus.pass, 0);
        chk("arst_sum", bus.sum, 0);
        chk("arst_err", bus.err, 0);
        tick();
        chk("arst_no_done", bus.done, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_done", bus.done, 0);
        pulse(21'd5);
        chk("post_rst_idle_err", bus.err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
